// File: rtl/div_mul_pkg.sv
// div_mul_pkg: shared FSM state type and default operand width for the divider/multiplier pair.
package div_mul_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic {ST_IDLE, ST_BUSY} state_e;
endpackage

// File: rtl/mul_secv_cu_rest_if.sv
// mul_secv_cu_rest_if: start/done handshake bundle carrying Q, B, R in and P, err out.
interface mul_secv_cu_rest_if
  import div_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   r;
  logic               start;
  logic [2*WIDTH-1:0] p;
  logic               busy;
  logic               done;
  logic               err;
  modport master (output q, b, r, start, input p, busy, done, err);
  modport slave  (input q, b, r, start, output p, busy, done, err);
endinterface

// File: rtl/mul_secv_cu_rest_step.sv
// mul_step: one shift-and-add iteration (conditional add, shift multiplicand left, multiplier right).
module mul_step #(
  parameter int WIDTH = 4
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [2*WIDTH-1:0] mc_i,
  input  logic [WIDTH-1:0]   mq_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [2*WIDTH-1:0] mc_o,
  output logic [WIDTH-1:0]   mq_o
);
  assign acc_o = mq_i[0] ? acc_i + mc_i : acc_i;
  assign mc_o  = mc_i << 1;
  assign mq_o  = mq_i >> 1;
endmodule

// File: rtl/mul_secv_cu_rest.sv
// mul_secv_cu_rest: sequential multiplier-accumulator computing P = Q*B + R, one product bit per clock.
module mul_secv_cu_rest
  import div_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  mul_secv_cu_rest_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mc_q, mc_d, acc_nx, mc_nx, p_q, p_d;
  logic [WIDTH-1:0]     mq_q, mq_d, mq_nx;
  logic [CW-1:0]        i_q, i_d;
  logic                 chk_q, chk_d, err_q, err_d, done_q, done_d;

  mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i(acc_q), .mc_i(mc_q), .mq_i(mq_q),
    .acc_o(acc_nx), .mc_o(mc_nx), .mq_o(mq_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      mc_q    <= '0;
      mq_q    <= '0;
      i_q     <= '0;
      chk_q   <= 1'b0;
      p_q     <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mc_q    <= mc_d;
      mq_q    <= mq_d;
      i_q     <= i_d;
      chk_q   <= chk_d;
      p_q     <= p_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mc_d    = mc_q;
    mq_d    = mq_q;
    i_d     = i_q;
    chk_d   = chk_q;
    p_d     = p_q;
    err_d   = err_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (bus.start) begin
        acc_d   = {{WIDTH{1'b0}}, bus.r};
        mc_d    = {{WIDTH{1'b0}}, bus.b};
        mq_d    = bus.q;
        i_d     = '0;
        chk_d   = bus.r >= bus.b;
        state_d = ST_BUSY;
      end
    end else begin
      acc_d = acc_nx;
      mc_d  = mc_nx;
      mq_d  = mq_nx;
      i_d   = i_q + CW'(1);
      // the final step's add lands directly in P
      if (i_q == LAST) begin
        p_d     = acc_nx;
        err_d   = chk_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  assign bus.p    = p_q;
  assign bus.err  = err_q;
  assign bus.done = done_q;
  assign bus.busy = state_q == ST_BUSY;
endmodule

// File: tb/tb_mul_secv_cu_rest.sv
// tb_mul_secv_cu_rest: randomized scoreboard bench for the Q*B+R multiplier-accumulator.
module tb_mul_secv_cu_rest;
  localparam int W = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_secv_cu_rest_if #(.WIDTH(W)) bus ();
  mul_secv_cu_rest #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    int p;
    bit err;
    int cyc;
  } exp_t;
  exp_t sb[$];
  int vec = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    vec++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic issue(input int q, input int b, input int r);
    int n = 0;
    exp_t e;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("issue_timeout", 1, 0);
    bus.q = q[W-1:0];
    bus.b = b[W-1:0];
    bus.r = r[W-1:0];
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    e.p = q * b + r;
    e.err = (r >= b);
    e.cyc = cyc + W;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) chk("spurious_done", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("P", int'(bus.p), e.p);
        chk("err", int'(bus.err), int'(e.err));
        chk("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    int n;
    bus.q = '0;
    bus.b = '0;
    bus.r = '0;
    bus.start = 1'b0;
    #1;
    chk("rst_P", int'(bus.p), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3, 5, 2);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      chk("busy_high", int'(bus.busy), 1);
    end
    @(negedge clk);
    chk("busy_low_at_done", int'(bus.busy), 0);
    chk("done_pulse", int'(bus.done), 1);
    @(negedge clk);
    chk("done_one_cycle", int'(bus.done), 0);
    issue(15, 15, 14);
    issue(7, 0, 3);
    issue(2, 5, 6);
    issue(9, 9, 9);
    @(negedge clk);
    @(negedge clk);
    bus.q = 4'd1;
    bus.b = 4'd1;
    bus.r = 4'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    issue(6, 4, 1);
    n = 0;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(bus.done), 1);
    issue(1, 1, 0);
    @(negedge clk);
    chk("P_held", int'(bus.p), 25);
    issue(5, 5, 5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_P", int'(bus.p), 0);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_done", int'(bus.done), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(3, 5, 2);
    repeat (40) issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drained", sb.size(), 0);
    repeat (W + 2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/mul_secv_cu_rest.md
# mul_secv_cu_rest

Sequential shift-and-add multiplier-accumulator that rebuilds a dividend from a division result: P = Q·B + R. It is the inverse companion of the restoring divider and sits on the same start/done (req/ack) handshake, so a divider result can be fed straight back for self-checking or for reconstruction. One product bit per clock; fixed latency independent of operand values.

## Interface
- WIDTH, 4, operand width (Q, B, R); P is 2·WIDTH bits; WIDTH ≥ 2
- clk  input  1  rising-edge clock, single clock domain
- rst_n  input  1  asynchronous, active-low reset
- Q  input  WIDTH  quotient (multiplier), sampled only on accepted start
- B  input  WIDTH  divisor (multiplicand), sampled only on accepted start
- R  input  WIDTH  remainder (addend), sampled only on accepted start
- start  input  1  request; accepted only when busy=0
- P  output  2·WIDTH  result Q·B + R; registered, holds until next result
- busy  output  1  high from the cycle after acceptance until result edge
- done  output  1  one-cycle ack pulse, P valid in the same cycle
- err  output  1  registered with P: 1 if R ≥ B (includes B=0), else 0

## Operation
- States: IDLE, BUSY.
- IDLE: start=1 at a clock edge → load acc ← zero-extended R, mc ← zero-extended B, mq ← Q, i ← 0, latch chk = (R ≥ B); go BUSY. start=0 → stay.
- BUSY, each edge: if mq[0] then acc ← acc + mc; mc ← mc << 1; mq ← mq >> 1; i ← i + 1.
- When i = WIDTH−1 at an edge: P ← final acc (including this step's add), err ← chk, done ← 1, go IDLE.
- Arithmetic: acc and mc are 2·WIDTH bits; max result (2^W−1)² + (2^W−1) = 2^(2W) − 2^W, no overflow, no carry out needed. Counter i is $clog2(WIDTH) bits, never wraps beyond WIDTH−1.
- err is a flag only; computation proceeds regardless. B=0 gives P=R, err=1.
- start while BUSY: ignored, no effect on operands or state.
- start in the done cycle: state is IDLE, so it is accepted; new operands load, P/err keep old values until the next result edge.
- Reset (any time, including mid-operation): abort, state IDLE, P=0, err=0, done=0, busy=0, internal registers cleared.

## Timing
- Acceptance edge t0 (start=1, state IDLE). busy=1 from t0 to t0+WIDTH.
- Result edge t0+WIDTH: P/err update, done=1 for exactly one cycle, busy=0.
- Latency start-edge to done: WIDTH cycles. Throughput: one operation per WIDTH cycles back-to-back.
- done deasserts at next edge unconditionally; no done back-pressure.
- Reset values: P=0, busy=0, done=0, err=0.

## Structure
- Shared package div_mul_pkg: state enum typedef (ST_IDLE, ST_BUSY), also used by the divider; default WIDTH constant.
- One natural sub-module: mul_step, combinational single iteration (acc, mc, mq → next acc, mc, mq); parent holds FSM, counter, registers.
- No memories, no multipliers inferred; adder is 2·WIDTH bits.

## Test plan
- WIDTH=4, Q=3, B=5, R=2, start one cycle → done exactly 4 cycles later, P=17, err=0, busy high for 4 cycles.
- Q=15, B=15, R=14 → P=239, err=0 (maximum-value case, no overflow).
- Q=7, B=0, R=3 → P=3, err=1; Q=2, B=5, R=6 → P=16, err=1.
- Start pulsed again 2 cycles into an operation with different operands → ignored; first result unchanged, single done pulse.
- Start asserted in the done cycle with Q=1, B=1, R=0 → accepted, second done 4 cycles later, P=1; first P held until then.
- rst_n low for one cycle mid-operation → P=0, busy=0, done never pulses for aborted op; next start computes correctly.
